// File: rtl/sy_npu_axi_dwc.sv
// -----------------------------------------------------------------------------
// sy_npu_axi_dwc
//   AXI data-width converter between a wide NPU port and a narrow AXI master.
//   Every NPU burst maps to one AXI INCR burst. Each wide beat is gathered
//   from, or split into, RATIO narrow beats, lowest slot first.
//   The read and write paths are independent FSMs, so one read burst and one
//   write burst can be in flight at the same time.
//
// Parameters
//   ADDR_WIDTH      AXI address width
//   NPU_ADDR_WIDTH  NPU address width
//   WIDE_DW         NPU data width
//   NARROW_DW       AXI data width (WIDE_DW/NARROW_DW must be 1, 2, 4 or 8)
//   NPU_BEATS       wide beats per NPU burst
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   base_addr_i           offset added to every NPU address
//   npu_ar*/npu_r*        NPU read address / read data (wide)
//   npu_aw*/npu_w*/npu_b* NPU write address / write data (wide) / response
//   ar_*/r_*              AXI read address / read data (narrow)
//   aw_*/w_*/b_*          AXI write address / write data (narrow) / response
// -----------------------------------------------------------------------------
module sy_npu_axi_dwc #(
  parameter int ADDR_WIDTH     = 64,
  parameter int NPU_ADDR_WIDTH = 29,
  parameter int WIDE_DW        = 128,
  parameter int NARROW_DW      = 64,
  parameter int NPU_BEATS      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               base_addr_i,
  // NPU read address
  input  logic                      npu_arvalid_i,
  output logic                      npu_arready_o,
  input  logic [NPU_ADDR_WIDTH-1:0] npu_araddr_i,
  // NPU read data
  output logic                      npu_rvalid_o,
  input  logic                      npu_rready_i,
  output logic [WIDE_DW-1:0]        npu_rdata_o,
  output logic                      npu_rlast_o,
  output logic [1:0]                npu_rresp_o,
  // NPU write address
  input  logic                      npu_awvalid_i,
  output logic                      npu_awready_o,
  input  logic [NPU_ADDR_WIDTH-1:0] npu_awaddr_i,
  // NPU write data
  input  logic                      npu_wvalid_i,
  output logic                      npu_wready_o,
  input  logic [WIDE_DW-1:0]        npu_wdata_i,
  input  logic [WIDE_DW/8-1:0]      npu_wstrb_i,
  input  logic                      npu_wlast_i,
  // NPU write response
  output logic                      npu_bvalid_o,
  input  logic                      npu_bready_i,
  output logic [1:0]                npu_bresp_o,
  // AXI read address
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [ADDR_WIDTH-1:0]     ar_addr_o,
  output logic [7:0]                ar_len_o,
  output logic [2:0]                ar_size_o,
  output logic [1:0]                ar_burst_o,
  // AXI write address
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [ADDR_WIDTH-1:0]     aw_addr_o,
  output logic [7:0]                aw_len_o,
  output logic [2:0]                aw_size_o,
  output logic [1:0]                aw_burst_o,
  // AXI read data
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [NARROW_DW-1:0]      r_data_i,
  input  logic                      r_last_i,
  input  logic [1:0]                r_resp_i,
  // AXI write data
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [NARROW_DW-1:0]      w_data_o,
  output logic [NARROW_DW/8-1:0]    w_strb_o,
  output logic                      w_last_o,
  // AXI write response
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [1:0]                b_resp_i
);

  localparam int RATIO = WIDE_DW / NARROW_DW;
  localparam int NSTRB = NARROW_DW / 8;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(RATIO - 1);
  localparam logic [7:0]       AXI_LEN    = 8'(NPU_BEATS * RATIO - 1);
  localparam logic [2:0]       AXI_SIZE   = 3'($clog2(NARROW_DW / 8));
  localparam logic [1:0]       BURST_INCR = 2'b01;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  if (!((RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8) &&
        (RATIO * NARROW_DW == WIDE_DW))) begin : g_bad_ratio
    $error("sy_npu_axi_dwc: WIDE_DW/NARROW_DW must be exactly 1, 2, 4 or 8");
  end

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_GATHER = 2'd1;
  localparam logic [1:0] R_OUT    = 2'd2;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_WAIT  = 2'd1;
  localparam logic [1:0] W_SPLIT = 2'd2;
  localparam logic [1:0] W_RESP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Constant burst attributes and address formation
  // ---------------------------------------------------------------------------
  assign ar_len_o   = AXI_LEN;
  assign aw_len_o   = AXI_LEN;
  assign ar_size_o  = AXI_SIZE;
  assign aw_size_o  = AXI_SIZE;
  assign ar_burst_o = BURST_INCR;
  assign aw_burst_o = BURST_INCR;

  assign ar_addr_o = ADDR_WIDTH'(npu_araddr_i) + ADDR_WIDTH'(base_addr_i);
  assign aw_addr_o = ADDR_WIDTH'(npu_awaddr_i) + ADDR_WIDTH'(base_addr_i);

  // ---------------------------------------------------------------------------
  // Read path: gather RATIO narrow beats into one wide beat
  // ---------------------------------------------------------------------------
  logic [1:0]         r_state_q, r_state_d;
  logic [CNT_W-1:0]   r_cnt_q,   r_cnt_d;
  logic [WIDE_DW-1:0] r_data_q,  r_data_d;
  logic [1:0]         r_resp_q,  r_resp_d;
  logic               r_last_q,  r_last_d;

  // NOTE: every _d takes its _q value first, so no path through the case
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    case (r_state_q)
      R_IDLE: begin
        if (npu_arvalid_i && ar_ready_i) begin
          r_state_d = R_GATHER;
          r_cnt_d   = '0;
          r_data_d  = '0;
          r_resp_d  = 2'b00;
          r_last_d  = 1'b0;
        end
      end
      R_GATHER: begin
        if (r_valid_i) begin
          for (int k = 0; k < RATIO; k++) begin
            if (r_cnt_q == CNT_W'(k)) r_data_d[k*NARROW_DW +: NARROW_DW] = r_data_i;
          end
          if (r_resp_i > r_resp_q) r_resp_d = r_resp_i;
          r_cnt_d = r_cnt_q + 1'b1;
          if (r_last_i && (r_cnt_q != LAST_SLOT)) begin
            // Burst ended short: untouched slots stay zero from the clear.
            r_resp_d  = RESP_SLVERR;
            r_last_d  = 1'b1;
            r_state_d = R_OUT;
          end else if (r_cnt_q == LAST_SLOT) begin
            r_last_d  = r_last_i;
            r_state_d = R_OUT;
          end
        end
      end
      R_OUT: begin
        if (npu_rready_i) begin
          r_state_d = r_last_q ? R_IDLE : R_GATHER;
          r_cnt_d   = '0;
          r_data_d  = '0;
          r_resp_d  = 2'b00;
          r_last_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // values from before the edge, whatever order the blocks run in.
  // NOTE: the data registers are reset as well, because npu_rdata_o and
  // w_data_o must read 0 while reset is held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_data_q  <= '0;
      r_resp_q  <= 2'b00;
      r_last_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
    end
  end

  // Address pass-throughs are gated by rst_i so they stay low during reset.
  assign ar_valid_o    = rst_i && (r_state_q == R_IDLE) && npu_arvalid_i;
  assign npu_arready_o = rst_i && (r_state_q == R_IDLE) && ar_ready_i;
  assign r_ready_o     = (r_state_q == R_GATHER);
  assign npu_rvalid_o  = (r_state_q == R_OUT);
  assign npu_rdata_o   = r_data_q;
  assign npu_rlast_o   = r_last_q;
  assign npu_rresp_o   = r_resp_q;

  // ---------------------------------------------------------------------------
  // Write path: split one wide beat into RATIO narrow beats
  // ---------------------------------------------------------------------------
  logic [1:0]         w_state_q, w_state_d;
  logic [CNT_W-1:0]   w_cnt_q,   w_cnt_d;
  logic [WIDE_DW-1:0] w_data_q,  w_data_d;
  logic [WIDE_DW/8-1:0] w_strb_q, w_strb_d;
  logic               w_last_q,  w_last_d;

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_last_d  = w_last_q;
    case (w_state_q)
      W_IDLE: begin
        if (npu_awvalid_i && aw_ready_i) w_state_d = W_WAIT;
      end
      W_WAIT: begin
        if (npu_wvalid_i) begin
          w_data_d  = npu_wdata_i;
          w_strb_d  = npu_wstrb_i;
          w_last_d  = npu_wlast_i;
          w_cnt_d   = '0;
          w_state_d = W_SPLIT;
        end
      end
      W_SPLIT: begin
        // Slots with an all-zero strobe are still sent, keeping the AXI beat
        // count equal to the advertised length.
        if (w_ready_i) begin
          w_cnt_d = w_cnt_q + 1'b1;
          if (w_cnt_q == LAST_SLOT) w_state_d = w_last_q ? W_RESP : W_WAIT;
        end
      end
      W_RESP: begin
        if (b_valid_i && npu_bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_last_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      w_last_q  <= w_last_d;
    end
  end

  logic [NARROW_DW-1:0] w_slot_data;
  logic [NSTRB-1:0]     w_slot_strb;

  always_comb begin
    w_slot_data = '0;
    w_slot_strb = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (w_cnt_q == CNT_W'(k)) begin
        w_slot_data = w_data_q[k*NARROW_DW +: NARROW_DW];
        w_slot_strb = w_strb_q[k*NSTRB +: NSTRB];
      end
    end
  end

  assign aw_valid_o    = rst_i && (w_state_q == W_IDLE) && npu_awvalid_i;
  assign npu_awready_o = rst_i && (w_state_q == W_IDLE) && aw_ready_i;
  assign npu_wready_o  = (w_state_q == W_WAIT);
  assign w_valid_o     = (w_state_q == W_SPLIT);
  assign w_data_o      = w_slot_data;
  assign w_strb_o      = w_slot_strb;
  assign w_last_o      = (w_state_q == W_SPLIT) && w_last_q && (w_cnt_q == LAST_SLOT);
  assign b_ready_o     = (w_state_q == W_RESP) && npu_bready_i;
  assign npu_bvalid_o  = (w_state_q == W_RESP) && b_valid_i;
  assign npu_bresp_o   = (w_state_q == W_RESP) ? b_resp_i : 2'b00;

endmodule

// File: tb/tb_sy_npu_axi_dwc.sv
// -----------------------------------------------------------------------------
// tb_sy_npu_axi_dwc
//   Directed bench for sy_npu_axi_dwc. One instance at default widths
//   (RATIO 2) and one with a 32-bit AXI side and NPU_BEATS 2 (RATIO 4).
//   Inputs change just after the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sy_npu_axi_dwc;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Default-width instance
  logic [31:0]  base_addr_i;
  logic         npu_arvalid_i, npu_arready_o;
  logic [28:0]  npu_araddr_i;
  logic         npu_rvalid_o, npu_rready_i, npu_rlast_o;
  logic [127:0] npu_rdata_o;
  logic [1:0]   npu_rresp_o;
  logic         npu_awvalid_i, npu_awready_o;
  logic [28:0]  npu_awaddr_i;
  logic         npu_wvalid_i, npu_wready_o, npu_wlast_i;
  logic [127:0] npu_wdata_i;
  logic [15:0]  npu_wstrb_i;
  logic         npu_bvalid_o, npu_bready_i;
  logic [1:0]   npu_bresp_o;
  logic         ar_valid_o, ar_ready_i, aw_valid_o, aw_ready_i;
  logic [63:0]  ar_addr_o, aw_addr_o;
  logic [7:0]   ar_len_o, aw_len_o;
  logic [2:0]   ar_size_o, aw_size_o;
  logic [1:0]   ar_burst_o, aw_burst_o;
  logic         r_valid_i, r_ready_o, r_last_i;
  logic [63:0]  r_data_i;
  logic [1:0]   r_resp_i;
  logic         w_valid_o, w_ready_i, w_last_o;
  logic [63:0]  w_data_o;
  logic [7:0]   w_strb_o;
  logic         b_valid_i, b_ready_o;
  logic [1:0]   b_resp_i;

  sy_npu_axi_dwc dut (
    .clk_i(clk_i), .rst_i(rst_i), .base_addr_i(base_addr_i),
    .npu_arvalid_i(npu_arvalid_i), .npu_arready_o(npu_arready_o), .npu_araddr_i(npu_araddr_i),
    .npu_rvalid_o(npu_rvalid_o), .npu_rready_i(npu_rready_i), .npu_rdata_o(npu_rdata_o),
    .npu_rlast_o(npu_rlast_o), .npu_rresp_o(npu_rresp_o),
    .npu_awvalid_i(npu_awvalid_i), .npu_awready_o(npu_awready_o), .npu_awaddr_i(npu_awaddr_i),
    .npu_wvalid_i(npu_wvalid_i), .npu_wready_o(npu_wready_o), .npu_wdata_i(npu_wdata_i),
    .npu_wstrb_i(npu_wstrb_i), .npu_wlast_i(npu_wlast_i),
    .npu_bvalid_o(npu_bvalid_o), .npu_bready_i(npu_bready_i), .npu_bresp_o(npu_bresp_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
    .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
    .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_last_i(r_last_i),
    .r_resp_i(r_resp_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i)
  );

  // RATIO 4 instance: only its read path is exercised
  logic         q_npu_arvalid_i, q_npu_arready_o;
  logic         q_npu_rvalid_o, q_npu_rlast_o;
  logic [127:0] q_npu_rdata_o;
  logic [1:0]   q_npu_rresp_o;
  logic         q_npu_awready_o, q_npu_wready_o, q_npu_bvalid_o;
  logic [1:0]   q_npu_bresp_o;
  logic         q_ar_valid_o, q_ar_ready_i, q_aw_valid_o;
  logic [63:0]  q_ar_addr_o, q_aw_addr_o;
  logic [7:0]   q_ar_len_o, q_aw_len_o;
  logic [2:0]   q_ar_size_o, q_aw_size_o;
  logic [1:0]   q_ar_burst_o, q_aw_burst_o;
  logic         q_r_valid_i, q_r_ready_o, q_r_last_i;
  logic [31:0]  q_r_data_i;
  logic         q_w_valid_o, q_w_last_o, q_b_ready_o;
  logic [31:0]  q_w_data_o;
  logic [3:0]   q_w_strb_o;

  sy_npu_axi_dwc #(.NARROW_DW(32), .NPU_BEATS(2)) dut_r4 (
    .clk_i(clk_i), .rst_i(rst_i), .base_addr_i(base_addr_i),
    .npu_arvalid_i(q_npu_arvalid_i), .npu_arready_o(q_npu_arready_o), .npu_araddr_i(29'h40),
    .npu_rvalid_o(q_npu_rvalid_o), .npu_rready_i(1'b1), .npu_rdata_o(q_npu_rdata_o),
    .npu_rlast_o(q_npu_rlast_o), .npu_rresp_o(q_npu_rresp_o),
    .npu_awvalid_i(1'b0), .npu_awready_o(q_npu_awready_o), .npu_awaddr_i(29'h0),
    .npu_wvalid_i(1'b0), .npu_wready_o(q_npu_wready_o), .npu_wdata_i(128'h0),
    .npu_wstrb_i(16'h0), .npu_wlast_i(1'b0),
    .npu_bvalid_o(q_npu_bvalid_o), .npu_bready_i(1'b0), .npu_bresp_o(q_npu_bresp_o),
    .ar_valid_o(q_ar_valid_o), .ar_ready_i(q_ar_ready_i), .ar_addr_o(q_ar_addr_o),
    .ar_len_o(q_ar_len_o), .ar_size_o(q_ar_size_o), .ar_burst_o(q_ar_burst_o),
    .aw_valid_o(q_aw_valid_o), .aw_ready_i(1'b0), .aw_addr_o(q_aw_addr_o),
    .aw_len_o(q_aw_len_o), .aw_size_o(q_aw_size_o), .aw_burst_o(q_aw_burst_o),
    .r_valid_i(q_r_valid_i), .r_ready_o(q_r_ready_o), .r_data_i(q_r_data_i),
    .r_last_i(q_r_last_i), .r_resp_i(2'b00),
    .w_valid_o(q_w_valid_o), .w_ready_i(1'b0), .w_data_o(q_w_data_o), .w_strb_o(q_w_strb_o),
    .w_last_o(q_w_last_o),
    .b_valid_i(1'b0), .b_ready_o(q_b_ready_o), .b_resp_i(2'b00)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_beat(input int i);
    return {32'hD0D0_0000 + 32'(i), 32'h1000_0000 + 32'(i * 16)};
  endfunction

  function automatic logic [127:0] wr_beat(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h3333_0000 + 32'(i),
            32'h2222_0000 + 32'(i), 32'h1111_0000 + 32'(i)};
  endfunction

  // Results collected by the bus tasks
  logic [127:0] rd_q[$];
  logic         rdl_q[$];
  logic [1:0]   rdr_q[$];
  bit           rd_done;
  int           rd_lat_bad;
  logic         ar_vld_noready;
  logic [63:0]  ar_addr_seen;
  logic [7:0]   ar_len_seen;
  logic [2:0]   ar_size_seen;
  logic [1:0]   ar_burst_seen;

  logic [63:0]  wd_q[$];
  logic [7:0]   ws_q[$];
  logic         wl_q[$];
  bit           wr_done;
  logic [1:0]   wb_resp_seen;
  logic         b_ready_seen;
  logic [63:0]  aw_addr_seen;
  logic [7:0]   aw_len_seen;
  logic [2:0]   aw_size_seen;
  logic [1:0]   aw_burst_seen;

  // One NPU read burst; the task plays the AXI slave and the NPU master.
  task automatic run_read(input logic [28:0] addr, input int n_narrow, input int last_at,
                          input bit thr, input int resp_beat);
    int  beat    = 0;
    int  cyc     = 0;
    int  last_hs = -10;
    bit  rv      = 1'b0;
    rd_q.delete(); rdl_q.delete(); rdr_q.delete();
    rd_done = 1'b0; rd_lat_bad = 0;
    @(negedge clk_i);
    npu_arvalid_i = 1'b1; npu_araddr_i = addr; ar_ready_i = 1'b0;
    #1 ar_vld_noready = ar_valid_o;
    @(negedge clk_i);
    ar_ready_i = 1'b1;
    #1;
    ar_addr_seen = ar_addr_o; ar_len_seen = ar_len_o;
    ar_size_seen = ar_size_o; ar_burst_seen = ar_burst_o;
    @(negedge clk_i);
    npu_arvalid_i = 1'b0; ar_ready_i = 1'b0;
    while (!rd_done && cyc < 400) begin
      if (!rv && beat < n_narrow) rv = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      r_valid_i = rv;
      r_data_i  = rd_beat(beat);
      r_last_i  = (beat == last_at);
      r_resp_i  = (beat == resp_beat) ? 2'b01 : 2'b00;
      #1;
      if (npu_rvalid_o) begin
        rd_q.push_back(npu_rdata_o);
        rdl_q.push_back(npu_rlast_o);
        rdr_q.push_back(npu_rresp_o);
        if (cyc != last_hs + 1) rd_lat_bad++;
        if (npu_rlast_o) rd_done = 1'b1;
      end
      if (rv && r_ready_o) begin
        rv = 1'b0; beat++; last_hs = cyc;
      end
      @(negedge clk_i);
      cyc++;
    end
    r_valid_i = 1'b0; r_last_i = 1'b0; r_resp_i = 2'b00;
    check("rd_done", rd_done, 1'b1);
  endtask

  // Four-beat NPU write burst; beat 2 carries strobe 0x00F0.
  task automatic run_write(input logic [28:0] addr, input bit thr);
    int wb  = 0;
    int nb  = 0;
    int cyc = 0;
    wd_q.delete(); ws_q.delete(); wl_q.delete();
    wr_done = 1'b0;
    @(negedge clk_i);
    npu_awvalid_i = 1'b1; npu_awaddr_i = addr; aw_ready_i = 1'b1;
    #1;
    aw_addr_seen = aw_addr_o; aw_len_seen = aw_len_o;
    aw_size_seen = aw_size_o; aw_burst_seen = aw_burst_o;
    @(negedge clk_i);
    npu_awvalid_i = 1'b0; aw_ready_i = 1'b0;
    while (!wr_done && cyc < 400) begin
      npu_wvalid_i = (wb < 4);
      npu_wdata_i  = wr_beat(wb);
      npu_wstrb_i  = (wb == 2) ? 16'h00F0 : 16'hFFFF;
      npu_wlast_i  = (wb == 3);
      w_ready_i    = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      b_valid_i    = (nb == 8);
      b_resp_i     = 2'b01;
      #1;
      if (w_valid_o && w_ready_i) begin
        wd_q.push_back(w_data_o); ws_q.push_back(w_strb_o); wl_q.push_back(w_last_o);
        nb++;
      end
      if (npu_wvalid_i && npu_wready_o) wb++;
      if (npu_bvalid_o && npu_bready_i) begin
        wb_resp_seen = npu_bresp_o; b_ready_seen = b_ready_o; wr_done = 1'b1;
      end
      @(negedge clk_i);
      cyc++;
    end
    npu_wvalid_i = 1'b0; npu_wlast_i = 1'b0; w_ready_i = 1'b0; b_valid_i = 1'b0;
    check("wr_done", wr_done, 1'b1);
  endtask

  // Full 8-narrow-beat read: wide beat i = {D(2i+1), D(2i)}.
  task automatic check_read_full(input string pfx, input int resp_wide);
    check({pfx, "_nbeats"}, 128'(rd_q.size()), 128'd4);
    check({pfx, "_latency"}, 128'(rd_lat_bad), 128'd0);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      check($sformatf("%s_data%0d", pfx, i), rd_q[i], {rd_beat(2*i+1), rd_beat(2*i)});
      check($sformatf("%s_last%0d", pfx, i), rdl_q[i], (i == 3));
      check($sformatf("%s_resp%0d", pfx, i), rdr_q[i], (i == resp_wide) ? 2'b01 : 2'b00);
    end
  endtask

  task automatic check_write_full(input string pfx);
    logic [127:0] wb;
    check({pfx, "_nbeats"}, 128'(wd_q.size()), 128'd8);
    for (int k = 0; k < 8 && k < wd_q.size(); k++) begin
      wb = wr_beat(k / 2);
      check($sformatf("%s_data%0d", pfx, k), wd_q[k], (k % 2 == 0) ? wb[63:0] : wb[127:64]);
      check($sformatf("%s_strb%0d", pfx, k), ws_q[k],
            (k == 4) ? 8'hF0 : (k == 5) ? 8'h00 : 8'hFF);
      check($sformatf("%s_last%0d", pfx, k), wl_q[k], (k == 7));
    end
    check({pfx, "_bresp"}, wb_resp_seen, 2'b01);
    check({pfx, "_bready"}, b_ready_seen, 1'b1);
  endtask

  initial begin
    logic [127:0] q_rd[$];
    logic         q_rl[$];
    int           qb;
    logic [127:0] exp_w;

    base_addr_i = 32'h8000_0000;
    npu_araddr_i = '0; npu_awaddr_i = '0; npu_wdata_i = '0; npu_wstrb_i = '0; npu_wlast_i = 1'b0;
    r_data_i = '0; r_last_i = 1'b0; r_resp_i = 2'b00; b_resp_i = 2'b00;
    npu_rready_i = 1'b1; npu_bready_i = 1'b1; w_ready_i = 1'b0;
    q_npu_arvalid_i = 1'b0; q_ar_ready_i = 1'b0; q_r_valid_i = 1'b0; q_r_last_i = 1'b0;
    q_r_data_i = '0;

    // Reset: pass-through inputs active, every handshake output must stay low
    npu_arvalid_i = 1'b1; ar_ready_i = 1'b1; npu_awvalid_i = 1'b1; aw_ready_i = 1'b1;
    r_valid_i = 1'b1; npu_wvalid_i = 1'b1; b_valid_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_handshakes", {ar_valid_o, npu_arready_o, aw_valid_o, npu_awready_o, r_ready_o,
                             w_valid_o, npu_rvalid_o, npu_wready_o, npu_bvalid_o, b_ready_o}, '0);
    check("rst_data", {npu_rdata_o, npu_rresp_o, npu_bresp_o}, '0);
    check("rst_wdata", {w_data_o, w_strb_o, w_last_o}, '0);
    npu_arvalid_i = 1'b0; ar_ready_i = 1'b0; npu_awvalid_i = 1'b0; aw_ready_i = 1'b0;
    r_valid_i = 1'b0; npu_wvalid_i = 1'b0; b_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;

    // Basic read burst
    run_read(29'h100, 8, 7, 1'b0, -1);
    check("rd_ar_valid_before_ready", ar_vld_noready, 1'b1);
    check("rd_ar_addr", ar_addr_seen, 64'h0000_0000_8000_0100);
    check("rd_ar_len", ar_len_seen, 8'd7);
    check("rd_ar_size", ar_size_seen, 3'd3);
    check("rd_ar_burst", ar_burst_seen, 2'b01);
    check_read_full("rd", -1);

    // Basic write burst with a partial and an empty strobe slot
    run_write(29'h2000, 1'b0);
    check("wr_aw_addr", aw_addr_seen, 64'h0000_0000_8000_2000);
    check("wr_aw_len", aw_len_seen, 8'd7);
    check("wr_aw_size", aw_size_seen, 3'd3);
    check("wr_aw_burst", aw_burst_seen, 2'b01);
    check_write_full("wr");

    // Concurrent read and write, both throttled; OKAY/EXOKAY mix on wide beat 2
    fork
      run_read(29'h300, 8, 7, 1'b1, 4);
      run_write(29'h400, 1'b1);
    join
    check("cc_ar_addr", ar_addr_seen, 64'h0000_0000_8000_0300);
    check("cc_aw_addr", aw_addr_seen, 64'h0000_0000_8000_0400);
    check_read_full("cc_rd", 2);
    check_write_full("cc_wr");

    // Early r_last on the third narrow beat
    run_read(29'h500, 3, 2, 1'b0, -1);
    check("early_nbeats", 128'(rd_q.size()), 128'd2);
    if (rd_q.size() == 2) begin
      check("early_data0", rd_q[0], {rd_beat(1), rd_beat(0)});
      check("early_last0", rdl_q[0], 1'b0);
      check("early_resp0", rdr_q[0], 2'b00);
      check("early_data1", rd_q[1], {64'h0, rd_beat(2)});
      check("early_last1", rdl_q[1], 1'b1);
      check("early_resp1", rdr_q[1], 2'b10);
    end
    @(negedge clk_i);
    ar_ready_i = 1'b1;
    #1;
    check("early_idle_arready", npu_arready_o, 1'b1);
    check("early_idle_rready", r_ready_o, 1'b0);
    ar_ready_i = 1'b0;

    // Reset during W_SPLIT slot 0
    @(negedge clk_i);
    npu_awvalid_i = 1'b1; npu_awaddr_i = 29'h700; aw_ready_i = 1'b1;
    @(negedge clk_i);
    npu_awvalid_i = 1'b0; aw_ready_i = 1'b0;
    npu_wvalid_i = 1'b1; npu_wdata_i = wr_beat(9); npu_wstrb_i = 16'hFFFF; npu_wlast_i = 1'b0;
    w_ready_i = 1'b0;
    @(negedge clk_i);
    npu_wvalid_i = 1'b0;
    #1;
    exp_w = wr_beat(9);
    check("mid_split_wvalid", w_valid_o, 1'b1);
    check("mid_split_wdata", w_data_o, exp_w[63:0]);
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_wvalid", w_valid_o, 1'b0);
    check("mid_rst_wdata", w_data_o, 64'h0);
    @(negedge clk_i);
    w_ready_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("post_rst_no_beat", w_valid_o, 1'b0);
    w_ready_i = 1'b0;
    run_write(29'h800, 1'b0);
    check("post_rst_aw_addr", aw_addr_seen, 64'h0000_0000_8000_0800);
    check_write_full("post_rst_wr");

    // RATIO 4 instance: 2 wide beats of 4 narrow beats each
    check("r4_ar_len", q_ar_len_o, 8'd7);
    check("r4_ar_size", q_ar_size_o, 3'd2);
    check("r4_aw_size", q_aw_size_o, 3'd2);
    @(negedge clk_i);
    q_npu_arvalid_i = 1'b1; q_ar_ready_i = 1'b1;
    #1;
    check("r4_ar_valid", q_ar_valid_o, 1'b1);
    check("r4_ar_addr", q_ar_addr_o, 64'h0000_0000_8000_0040);
    @(negedge clk_i);
    q_npu_arvalid_i = 1'b0; q_ar_ready_i = 1'b0;
    qb = 0;
    for (int cyc = 0; cyc < 60 && q_rd.size() < 2; cyc++) begin
      q_r_valid_i = (qb < 8);
      q_r_data_i  = 32'hE000_0000 + 32'(qb);
      q_r_last_i  = (qb == 7);
      #1;
      if (q_npu_rvalid_o) begin
        q_rd.push_back(q_npu_rdata_o); q_rl.push_back(q_npu_rlast_o);
      end
      if (q_r_valid_i && q_r_ready_o) qb++;
      @(negedge clk_i);
    end
    q_r_valid_i = 1'b0; q_r_last_i = 1'b0;
    check("r4_nbeats", 128'(q_rd.size()), 128'd2);
    if (q_rd.size() == 2) begin
      check("r4_data0", q_rd[0], 128'hE000_0003_E000_0002_E000_0001_E000_0000);
      check("r4_last0", q_rl[0], 1'b0);
      check("r4_data1", q_rd[1], 128'hE000_0007_E000_0006_E000_0005_E000_0004);
      check("r4_last1", q_rl[1], 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sy_npu_axi_dwc.md
SY_NPU_AXI_DWC -- requirements
Module: sy_npu_axi_dwc

Interface
Parameters:
REQ-001 SHALL provide the following parameters:
- ADDR_WIDTH, 64: narrow-side AXI address width.
- NPU_ADDR_WIDTH, 29: NPU-side address width.
- WIDE_DW, 128: NPU-side data width.
- NARROW_DW, 64: AXI-side data width.
- NPU_BEATS, 4: wide beats per NPU burst.
REQ-002 SHALL define RATIO = WIDE_DW/NARROW_DW and reject any value outside {1,2,4,8} at elaboration.

Ports (name, direction, width, meaning):
REQ-003 SHALL provide clk_i, in, 1: single clock, rising edge.
REQ-004 SHALL provide rst_i, in, 1: asynchronous, active-low reset.
REQ-005 SHALL provide base_addr_i, in, 32: offset added to every NPU address.
REQ-006 SHALL provide the NPU read-address group:
- npu_arvalid_i, in, 1
- npu_arready_o, out, 1
- npu_araddr_i, in, NPU_ADDR_WIDTH
REQ-007 SHALL provide the NPU read-data group:
- npu_rvalid_o, out, 1
- npu_rready_i, in, 1
- npu_rdata_o, out, WIDE_DW
- npu_rlast_o, out, 1
- npu_rresp_o, out, 2
REQ-008 SHALL provide the NPU write-address group:
- npu_awvalid_i, in, 1
- npu_awready_o, out, 1
- npu_awaddr_i, in, NPU_ADDR_WIDTH
REQ-009 SHALL provide the NPU write-data group:
- npu_wvalid_i, in, 1
- npu_wready_o, out, 1
- npu_wdata_i, in, WIDE_DW
- npu_wstrb_i, in, WIDE_DW/8
- npu_wlast_i, in, 1
REQ-010 SHALL provide the NPU write-response group:
- npu_bvalid_o, out, 1
- npu_bready_i, in, 1
- npu_bresp_o, out, 2
REQ-011 SHALL provide the AXI address channels:
- ar_valid_o, out, 1; ar_ready_i, in, 1; ar_addr_o, out, ADDR_WIDTH; ar_len_o, out, 8
- aw_valid_o, out, 1; aw_ready_i, in, 1; aw_addr_o, out, ADDR_WIDTH; aw_len_o, out, 8
- ar_size_o / aw_size_o, out, 3; ar_burst_o / aw_burst_o, out, 2
REQ-012 SHALL provide the AXI data channels:
- r_valid_i, in, 1; r_ready_o, out, 1; r_data_i, in, NARROW_DW; r_last_i, in, 1; r_resp_i, in, 2
- w_valid_o, out, 1; w_ready_i, in, 1; w_data_o, out, NARROW_DW; w_strb_o, out, NARROW_DW/8; w_last_o, out, 1
- b_valid_i, in, 1; b_ready_o, out, 1; b_resp_i, in, 2

Function
REQ-013 SHALL drive the following constants:
- len = NPU_BEATS*RATIO-1 (7 at defaults)
- size = log2(NARROW_DW/8)
- burst = INCR (2'b01)
REQ-014 SHALL form each AXI address as zero-extended NPU address + zero-extended base_addr_i, modulo 2^ADDR_WIDTH; the sum is combinational.
REQ-015 SHALL run the read and write FSMs independently, so one read burst and one write burst may be in flight concurrently.
REQ-016 SHALL map narrow slots so that slot k covers wide bits [k*NARROW_DW +: NARROW_DW]; slot 0 goes first on the AXI side.
REQ-017 Read FSM states SHALL be R_IDLE, R_GATHER and R_OUT.
REQ-018 In R_IDLE:
- ar_valid_o = npu_arvalid_i and npu_arready_o = ar_ready_i.
- On handshake: go to R_GATHER and clear the slot counter.
REQ-019 In R_GATHER:
- r_ready_o = 1; each r beat is stored in the current slot and the counter increments.
- After slot RATIO-1: go to R_OUT.
REQ-020 In R_OUT:
- npu_rvalid_o = 1; data is registered; npu_rlast_o = r_last_i of the final narrow beat.
- npu_rresp_o = numerically largest r_resp_i of the gathered beats.
- On npu_rready_i: go to R_IDLE if last, else to R_GATHER.
- Latency: npu_rvalid_o asserts 1 cycle after the final narrow-beat handshake.
REQ-021 On r_last_i at a slot other than RATIO-1:
- Unfilled slots read as 0, npu_rresp_o = 2'b10, npu_rlast_o = 1.
- The FSM proceeds via R_OUT to R_IDLE.
REQ-022 Write FSM states SHALL be W_IDLE, W_WAIT, W_SPLIT and W_RESP.
REQ-023 In W_IDLE:
- aw_valid_o = npu_awvalid_i and npu_awready_o = aw_ready_i.
- On handshake: go to W_WAIT.
REQ-024 In W_WAIT:
- npu_wready_o = 1.
- On npu_wvalid_i: register data, strb and last; clear the counter; go to W_SPLIT.
REQ-025 In W_SPLIT:
- w_valid_o = 1; w_data_o / w_strb_o = current slot; w_last_o = wlast_q AND counter == RATIO-1.
- Each w_ready_i increments the counter.
- After slot RATIO-1: go to W_RESP if wlast_q, else to W_WAIT.
REQ-026 All-zero strobe slots SHALL still be issued as beats.
REQ-027 In W_RESP:
- b_ready_o = npu_bready_i, npu_bvalid_o = b_valid_i, npu_bresp_o = b_resp_i.
- On handshake: go to W_IDLE.
REQ-028 When RATIO = 1, each wide beat SHALL map to exactly one narrow beat with the same FSM flow.
REQ-029 Valid signals SHALL never depend combinationally on the ready they await; once asserted, valid SHALL hold until its handshake.

Reset
REQ-030 While rst_i = 0, the block SHALL hold:
- Both FSMs idle, counters 0, data/strb/last registers 0.
- All valid/ready outputs 0.
- npu_rdata_o = 0; npu_rresp_o = npu_bresp_o = 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no further beats issued; operation restarts from idle on the first clock edge after rst_i rises.

Verification
REQ-032 Defaults, base 0x8000_0000, npu_araddr 0x100, 8 narrow beats D0..D7 -> ar_addr_o = 0x8000_0100, ar_len_o = 7, ar_size_o = 3; 4 wide beats {D1,D0}..{D7,D6}; rlast only on the 4th; rresp = 0.
REQ-033 Write of 4 wide beats, strb 0xFFFF except beat 2 = 0x00F0 -> 8 w beats, low half first; beat 4 strb 0xF0, beat 5 strb 0x00; w_last_o only on beat 8; b relayed.
REQ-034 Concurrent read and write, with w_ready_i/r_valid_i randomly throttled 50% -> both bursts complete, data intact, no cross-channel stall.
REQ-035 Read with r_last_i on narrow beat 3 and r_resp_i = 0 -> wide beat 2 = {0,D2}, npu_rresp_o = 2'b10, npu_rlast_o = 1, FSM in R_IDLE.
REQ-036 rst_i low during W_SPLIT slot 0 -> w_valid_o = 0 immediately; the next AW is accepted normally after reset release.
REQ-037 NARROW_DW = 32 (RATIO = 4), NPU_BEATS = 2 -> ar_len_o = 7, ar_size_o = 2; 4 narrow beats per wide beat.
